// File: rtl/wishbone_memory_bridge_if.sv
// Wishbone classic (B3) master/slave signal bundle for the memory bridge.
// Latency: none, wires only.
// Backpressure: slave stalls the master by withholding wb_ack_i / wb_err_i.
// Ports: none; signals grouped under master (bridge) and slave (memory) modports.
interface wishbone_memory_bridge_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wishbone_memory_bridge.sv
// Turns one controller memory request into one Wishbone classic cycle.
// Latency: memory_done 2 cycles after the request with a zero-wait slave, +1 per wait state.
// Backpressure: requests are taken in IDLE only; requests while busy are dropped.
// Ports: clk/reset (async active-low); controller side memory_request, memory_command,
//   read/write addresses, write data, sel_i in; read_memory_data, memory_busy,
//   memory_done, bus_error, bus_timeout out; wb = Wishbone master modport.
module wishbone_memory_bridge #(
  parameter int          TIMEOUT_CYCLES  = 255,
  parameter logic [31:0] RESET_READ_DATA = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           memory_request,
  input  logic                           memory_command,
  input  logic [31:0]                    read_memory_address,
  input  logic [31:0]                    write_memory_address,
  input  logic [31:0]                    write_memory_data,
  input  logic [3:0]                     sel_i,
  output logic [31:0]                    read_memory_data,
  output logic                           memory_busy,
  output logic                           memory_done,
  output logic                           bus_error,
  output logic                           bus_timeout,
  wishbone_memory_bridge_if.master       wb
);

  // Controller command encoding: READ = 0, WRITE = 1.
  localparam logic CMD_WRITE = 1'b1;

  // Counter only needs to reach TIMEOUT_CYCLES-1; it saturates at all-ones.
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

  state_t      r_state, w_next;
  logic [CW-1:0] r_count;
  logic        r_cyc, r_stb, r_we;
  logic [31:0] r_adr, r_dat;
  logic [3:0]  r_sel;
  logic [31:0] r_rdata;
  logic        r_busy, r_done, r_error, r_timeout;

  logic        w_is_write;
  logic [31:0] w_addr;
  logic        w_timeout_hit;
  logic        w_leave;

  assign w_is_write    = (memory_command == CMD_WRITE);
  assign w_addr        = w_is_write ? write_memory_address : read_memory_address;
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_count == TO_LAST);
  assign w_leave       = wb.wb_err_i || wb.wb_ack_i || w_timeout_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (memory_request) w_next = ACCESS;
      ACCESS:   if (w_leave)        w_next = COMPLETE;
      COMPLETE:                     w_next = IDLE;
      default:                      w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_timeout <= 1'b0;
      r_rdata   <= RESET_READ_DATA;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (memory_request) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_busy  <= 1'b1;
            r_we    <= w_is_write;
            r_adr   <= w_addr & 32'hFFFF_FFFC;
            r_dat   <= write_memory_data;
            r_sel   <= w_is_write ? sel_i : 4'hF;
            r_count <= '0;
          end
        end
        ACCESS: begin
          if (w_leave) begin
            r_cyc  <= 1'b0;
            r_stb  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            // err outranks ack, ack outranks the timeout.
            if (wb.wb_err_i) begin
              r_error   <= 1'b1;
              r_timeout <= 1'b0;
            end else if (wb.wb_ack_i) begin
              r_error   <= 1'b0;
              r_timeout <= 1'b0;
              if (!r_we) r_rdata <= wb.wb_dat_i;
            end else begin
              r_error   <= 1'b1;
              r_timeout <= 1'b1;
            end
          end else if (r_count != '1) begin
            r_count <= r_count + 1'b1;
          end
        end
        COMPLETE: begin
          r_done    <= 1'b0;
          r_error   <= 1'b0;
          r_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign wb.wb_cyc_o      = r_cyc;
  assign wb.wb_stb_o      = r_stb;
  assign wb.wb_we_o       = r_we;
  assign wb.wb_adr_o      = r_adr;
  assign wb.wb_dat_o      = r_dat;
  assign wb.wb_sel_o      = r_sel;
  assign read_memory_data = r_rdata;
  assign memory_busy      = r_busy;
  assign memory_done      = r_done;
  assign bus_error        = r_error;
  assign bus_timeout      = r_timeout;

endmodule

// File: tb/tb_wishbone_memory_bridge.sv
// Directed bench for the Wishbone memory bridge: main instance with a 4-cycle
// timeout, second instance with the timeout disabled and a slave that never answers.
module tb_wishbone_memory_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_request;
  logic        memory_command;
  logic [31:0] read_memory_address;
  logic [31:0] write_memory_address;
  logic [31:0] write_memory_data;
  logic [3:0]  sel_i;

  logic [31:0] read_memory_data, read_memory_data0;
  logic        memory_busy, memory_done, bus_error, bus_timeout;
  logic        memory_busy0, memory_done0, bus_error0, bus_timeout0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc_starts = 0;
  int done0_cnt = 0;
  logic prev_cyc = 1'b0;
  int d_snap, c_snap;

  wishbone_memory_bridge_if wb ();
  wishbone_memory_bridge_if wb0 ();

  always #5 clk = ~clk;

  wishbone_memory_bridge #(.TIMEOUT_CYCLES(4), .RESET_READ_DATA(32'h0000_0013)) dut (
    .clk(clk), .reset(reset),
    .memory_request(memory_request), .memory_command(memory_command),
    .read_memory_address(read_memory_address), .write_memory_address(write_memory_address),
    .write_memory_data(write_memory_data), .sel_i(sel_i),
    .read_memory_data(read_memory_data), .memory_busy(memory_busy),
    .memory_done(memory_done), .bus_error(bus_error), .bus_timeout(bus_timeout),
    .wb(wb.master)
  );

  wishbone_memory_bridge #(.TIMEOUT_CYCLES(0), .RESET_READ_DATA(32'h0000_0013)) dut0 (
    .clk(clk), .reset(reset),
    .memory_request(memory_request), .memory_command(memory_command),
    .read_memory_address(read_memory_address), .write_memory_address(write_memory_address),
    .write_memory_data(write_memory_data), .sel_i(sel_i),
    .read_memory_data(read_memory_data0), .memory_busy(memory_busy0),
    .memory_done(memory_done0), .bus_error(bus_error0), .bus_timeout(bus_timeout0),
    .wb(wb0.master)
  );

  always @(negedge clk) begin
    if (memory_done)  done_cnt++;
    if (memory_done0) done0_cnt++;
    if (wb.wb_cyc_o && !prev_cyc) cyc_starts++;
    prev_cyc = wb.wb_cyc_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic cmd, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel);
    memory_request = 1'b1;
    memory_command = cmd;
    if (cmd) write_memory_address = addr;
    else     read_memory_address  = addr;
    write_memory_data = data;
    sel_i = sel;
  endtask

  initial begin
    reset = 1'b0;
    memory_request = 1'b0; memory_command = 1'b0;
    read_memory_address = '0; write_memory_address = '0;
    write_memory_data = '0; sel_i = '0;
    wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_dat_i = '0;
    wb0.wb_ack_i = 1'b0; wb0.wb_err_i = 1'b0; wb0.wb_dat_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cyc",   wb.wb_cyc_o,  0);
    check("rst_stb",   wb.wb_stb_o,  0);
    check("rst_we",    wb.wb_we_o,   0);
    check("rst_adr",   wb.wb_adr_o,  0);
    check("rst_dat",   wb.wb_dat_o,  0);
    check("rst_sel",   wb.wb_sel_o,  0);
    check("rst_busy",  memory_busy,  0);
    check("rst_done",  memory_done,  0);
    check("rst_err",   bus_error,    0);
    check("rst_tmo",   bus_timeout,  0);
    check("rst_rdata", read_memory_data, 32'h0000_0013);
    reset = 1'b1;
    @(negedge clk);

    // Read, zero-wait slave
    issue(1'b0, 32'h0000_1006, 32'h0, 4'h0);
    @(negedge clk);
    memory_request = 1'b0;
    check("rd_cyc",  wb.wb_cyc_o, 1);
    check("rd_stb",  wb.wb_stb_o, 1);
    check("rd_we",   wb.wb_we_o,  0);
    check("rd_adr",  wb.wb_adr_o, 32'h0000_1004);
    check("rd_sel",  wb.wb_sel_o, 4'hF);
    check("rd_busy", memory_busy, 1);
    check("rd_done_early", memory_done, 0);
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'h0;
    check("rd_done",  memory_done, 1);
    check("rd_cyc_drop", wb.wb_cyc_o, 0);
    check("rd_busy_drop", memory_busy, 0);
    check("rd_err",   bus_error, 0);
    check("rd_rdata", read_memory_data, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rd_done_pulse", memory_done, 0);

    // Write with 3 wait states
    issue(1'b1, 32'h0000_2000, 32'h0000_AB00, 4'b0010);
    @(negedge clk);
    memory_request = 1'b0;
    check("wr_we",  wb.wb_we_o,  1);
    check("wr_sel", wb.wb_sel_o, 4'b0010);
    check("wr_adr", wb.wb_adr_o, 32'h0000_2000);
    check("wr_dat", wb.wb_dat_o, 32'h0000_AB00);
    for (int i = 0; i < 4; i++) begin
      check("wr_cyc_hold", wb.wb_cyc_o, 1);
      check("wr_no_done",  memory_done, 0);
      if (i == 3) wb.wb_ack_i = 1'b1;
      @(negedge clk);
    end
    wb.wb_ack_i = 1'b0;
    check("wr_done",  memory_done, 1);
    check("wr_cyc_drop", wb.wb_cyc_o, 0);
    check("wr_err",   bus_error, 0);
    check("wr_rdata_held", read_memory_data, 32'hDEAD_BEEF);
    @(negedge clk);

    // Error with simultaneous ack: err wins, read data untouched
    issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    @(negedge clk);
    memory_request = 1'b0;
    wb.wb_ack_i = 1'b1; wb.wb_err_i = 1'b1; wb.wb_dat_i = 32'h1234_5678;
    @(negedge clk);
    wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_dat_i = 32'h0;
    check("er_done",  memory_done, 1);
    check("er_err",   bus_error,   1);
    check("er_tmo",   bus_timeout, 0);
    check("er_rdata", read_memory_data, 32'hDEAD_BEEF);
    @(negedge clk);
    check("er_err_clr", bus_error, 0);

    // Timeout after 4 ACCESS cycles
    issue(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    @(negedge clk);
    memory_request = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_cyc_hold", wb.wb_cyc_o, 1);
      check("to_no_done",  memory_done, 0);
      @(negedge clk);
    end
    check("to_done",  memory_done, 1);
    check("to_err",   bus_error,   1);
    check("to_tmo",   bus_timeout, 1);
    check("to_rdata", read_memory_data, 32'hDEAD_BEEF);
    @(negedge clk);
    check("to_tmo_clr", bus_timeout, 0);
    check("to_done_clr", memory_done, 0);

    // Requests during ACCESS and COMPLETE are ignored
    d_snap = done_cnt; c_snap = cyc_starts;
    issue(1'b1, 32'h0000_5000, 32'h0000_1111, 4'hF);
    @(negedge clk);
    memory_request = 1'b0;
    @(negedge clk);
    memory_request = 1'b1;
    @(negedge clk);
    memory_request = 1'b0;
    wb.wb_ack_i = 1'b1;
    @(negedge clk);
    wb.wb_ack_i = 1'b0;
    check("bz_done", memory_done, 1);
    memory_request = 1'b1;
    @(negedge clk);
    memory_request = 1'b0;
    repeat (3) @(negedge clk);
    check("bz_one_done", done_cnt - d_snap, 1);
    check("bz_one_cyc",  cyc_starts - c_snap, 1);
    check("bz_idle_cyc", wb.wb_cyc_o, 0);

    // Timeout disabled: second instance still waiting on its first access
    repeat (1000) @(negedge clk);
    check("t0_cyc",  wb0.wb_cyc_o, 1);
    check("t0_busy", memory_busy0, 1);
    check("t0_no_done", done0_cnt, 0);

    // Reset asserted mid-ACCESS
    d_snap = done_cnt;
    issue(1'b0, 32'h0000_6000, 32'h0, 4'h0);
    @(negedge clk);
    memory_request = 1'b0;
    check("mr_cyc_before", wb.wb_cyc_o, 1);
    #2 reset = 1'b0;
    #1;
    check("mr_cyc_async", wb.wb_cyc_o, 0);
    check("mr_stb_async", wb.wb_stb_o, 0);
    check("mr_busy",  memory_busy, 0);
    check("mr_rdata", read_memory_data, 32'h0000_0013);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("mr_no_done", done_cnt - d_snap, 0);
    check("mr_idle_cyc", wb.wb_cyc_o, 0);
    check("mr_rdata_after", read_memory_data, 32'h0000_0013);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
